// File: rtl/quad_dec_bictr_if.sv
// Bundle of the encoder pins, count control/data and status outputs of
// quad_dec_bictr. clk and reset stay plain ports on the module.
interface quad_dec_bictr_if #(
  parameter int unsigned width = 13
);
  logic             a_in;
  logic             b_in;
  logic             idx_in;
  logic             idx_en;
  logic [width-1:0] data;
  logic             load;
  logic             cen;
  logic [width-1:0] count_to;
  logic [width-1:0] count;
  logic             up_dn;
  logic             step;
  logic             err;
  logic             tercnt;

  modport master (
    output a_in, b_in, idx_in, idx_en, data, load, cen, count_to,
    input  count, up_dn, step, err, tercnt
  );

  modport slave (
    input  a_in, b_in, idx_in, idx_en, data, load, cen, count_to,
    output count, up_dn, step, err, tercnt
  );
endinterface

// File: rtl/quad_dec_bictr.sv
// x4 quadrature decoder feeding an up/down position counter with a
// combinational terminal-count compare. Encoder pins are asynchronous and
// pass a 2-flop synchroniser. Define QDEC_FILTER_EN to insert a per-phase
// glitch filter (flt_len stable samples) between synchroniser and decoder.
module quad_dec_bictr #(
  parameter int unsigned width   = 13,
  parameter int unsigned flt_len = 3
) (
  input logic              clk,
  input logic              reset,
  quad_dec_bictr_if.slave  bus
);

  if (width < 2 || width > 32) begin : g_bad_width
    $error("quad_dec_bictr: width must be 2..32");
  end
  if (flt_len < 1 || flt_len > 15) begin : g_bad_flt
    $error("quad_dec_bictr: flt_len must be 1..15");
  end

  typedef enum logic {ST_PRIME, ST_RUN} state_t;

  // bit 0 = A, bit 1 = B, bit 2 = index
  logic [2:0]       meta;
  logic [2:0]       synced;
  logic             a_lvl;
  logic             b_lvl;
  logic [1:0]       p_now;
  logic [1:0]       p_prev;
  logic [1:0]       delta;
  logic             idx_prev;
  logic             idx_rise;
  state_t           state;
  state_t           state_next;
  logic             step_up;
  logic             step_dn;
  logic             bad;
  logic [width-1:0] count_r;
  logic             up_dn_r;
  logic             step_r;
  logic             err_r;

  // two-flop synchroniser for the asynchronous encoder pins
  always_ff @(posedge clk) begin
    if (reset) begin
      meta   <= '0;
      synced <= '0;
    end else begin
      meta   <= {bus.idx_in, bus.b_in, bus.a_in};
      synced <= meta;
    end
  end

`ifdef QDEC_FILTER_EN
  logic [3:0] a_cnt;
  logic [3:0] b_cnt;
  logic       a_flt;
  logic       b_flt;

  // accept a new phase level only after flt_len consecutive differing samples
  always_ff @(posedge clk) begin
    if (reset) begin
      a_cnt <= '0;
      b_cnt <= '0;
      a_flt <= 1'b0;
      b_flt <= 1'b0;
    end else begin
      if (synced[0] != a_flt) begin
        if (a_cnt == 4'(flt_len - 1)) begin
          a_flt <= synced[0];
          a_cnt <= '0;
        end else begin
          a_cnt <= a_cnt + 4'd1;
        end
      end else begin
        a_cnt <= '0;
      end
      if (synced[1] != b_flt) begin
        if (b_cnt == 4'(flt_len - 1)) begin
          b_flt <= synced[1];
          b_cnt <= '0;
        end else begin
          b_cnt <= b_cnt + 4'd1;
        end
      end else begin
        b_cnt <= '0;
      end
    end
  end

  assign a_lvl = a_flt;
  assign b_lvl = b_flt;
`else
  assign a_lvl = synced[0];
  assign b_lvl = synced[1];
`endif

  // Gray phase code: the modulo-4 difference of consecutive codes gives direction
  always_comb begin
    p_now = 2'd0;
    case ({a_lvl, b_lvl})
      2'b00:   p_now = 2'd0;
      2'b10:   p_now = 2'd1;
      2'b11:   p_now = 2'd2;
      default: p_now = 2'd3;
    endcase
    delta = p_now - p_prev;
  end

  assign idx_rise = synced[2] & ~idx_prev;

  // priming state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_PRIME;
    end else begin
      state <= state_next;
    end
  end

  // step/error decode; nothing is reported while the previous phase is being primed
  always_comb begin
    state_next = state;
    step_up    = 1'b0;
    step_dn    = 1'b0;
    bad        = 1'b0;
    case (state)
      ST_PRIME: state_next = ST_RUN;
      ST_RUN: begin
        case (delta)
          2'd1:    step_up = 1'b1;
          2'd3:    step_dn = 1'b1;
          2'd2:    bad     = 1'b1;
          default: ;
        endcase
      end
      default: state_next = ST_PRIME;
    endcase
  end

  // previous phase and previous index samples, tracked every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      p_prev   <= '0;
      idx_prev <= 1'b0;
    end else begin
      p_prev   <= p_now;
      idx_prev <= synced[2];
    end
  end

  // position counter: load, then index clear, then enabled step; others hold
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
      up_dn_r <= 1'b1;
      step_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      step_r <= 1'b0;
      err_r  <= bad;
      if (!bus.load) begin
        count_r <= bus.data;
      end else if (bus.idx_en && idx_rise) begin
        count_r <= '0;
      end else if ((step_up || step_dn) && bus.cen) begin
        count_r <= step_up ? count_r + width'(1) : count_r - width'(1);
        up_dn_r <= step_up;
        step_r  <= 1'b1;
      end
    end
  end

  assign bus.count  = count_r;
  assign bus.up_dn  = up_dn_r;
  assign bus.step   = step_r;
  assign bus.err    = err_r;
  assign bus.tercnt = (count_r == bus.count_to);

endmodule

// File: tb/tb_quad_dec_bictr.sv
// Self-checking bench for quad_dec_bictr (width 13, flt_len 3): reset state,
// a vector table for reverse wrap / error / tercnt, hand sequences for the
// multi-cycle corner cases, and randomized traffic against a reference model.
module tb_quad_dec_bictr;

`ifdef QDEC_FILTER_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 3;
`endif
  localparam int MODV = 8192;

  logic clk = 1'b0;
  logic reset = 1'b1;

  quad_dec_bictr_if #(.width(13)) bus ();

  quad_dec_bictr #(.width(13), .flt_len(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_step = 0;
  int n_err  = 0;
  bit chk_model = 1'b0;

  // reference model: synchroniser is a 2-entry delay queue of pin samples
  bit [2:0] q[$];
  int       m_pos;
  bit       m_up;
  bit       m_step;
  bit       m_err;
  bit       m_primed;
  int       m_prev_ph;
  bit       m_prev_idx;

  typedef struct {
    bit [1:0] ab;
    int       exp_count;
    bit       exp_up;
    bit       exp_step;
    bit       exp_err;
    bit       exp_ter;
  } vec_t;

  vec_t tbl[11];

  function automatic int phase_of(bit a, bit b);
    if (a) return b ? 2 : 1;
    return b ? 3 : 0;
  endfunction

  function automatic bit [1:0] ab_of(int p);
    case (p % 4)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic model_edge();
    bit [2:0] cur;
    int ph, d;
    bit rise, mv;
    if (reset) begin
      m_pos = 0; m_up = 1; m_step = 0; m_err = 0;
      m_primed = 0; m_prev_ph = 0; m_prev_idx = 0;
      q.delete();
      q.push_back(3'b000);
      q.push_back(3'b000);
    end else begin
      cur = q.pop_front();
      q.push_back({bus.idx_in, bus.b_in, bus.a_in});
      ph   = phase_of(cur[0], cur[1]);
      d    = (ph - m_prev_ph + 4) % 4;
      rise = cur[2] && !m_prev_idx;
      mv   = m_primed && (d == 1 || d == 3);
      m_err  = m_primed && (d == 2);
      m_step = 0;
      if (!bus.load) m_pos = int'(bus.data);
      else if (bus.idx_en && rise) m_pos = 0;
      else if (mv && bus.cen) begin
        m_pos  = (d == 1) ? (m_pos + 1) % MODV : (m_pos + MODV - 1) % MODV;
        m_up   = (d == 1);
        m_step = 1;
      end
      m_prev_ph  = ph;
      m_prev_idx = cur[2];
      m_primed   = 1;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    n_step += int'(bus.step);
    n_err  += int'(bus.err);
    if (chk_model) begin
      chk("rnd_count",  int'(bus.count),  m_pos);
      chk("rnd_up_dn",  int'(bus.up_dn),  int'(m_up));
      chk("rnd_step",   int'(bus.step),   int'(m_step));
      chk("rnd_err",    int'(bus.err),    int'(m_err));
      chk("rnd_tercnt", int'(bus.tercnt), int'(m_pos == int'(bus.count_to)));
    end
  endtask

  task automatic set_ab(input bit [1:0] ab);
    bus.a_in = ab[1];
    bus.b_in = ab[0];
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    bit [1:0] glitch_ab;
    int first_step;
    int cur_ph;
    int r;

    bus.a_in = 0; bus.b_in = 0; bus.idx_in = 0; bus.idx_en = 0;
    bus.data = '0; bus.load = 1; bus.cen = 1; bus.count_to = '0;

    // reset state
    reset = 1'b1;
    cyc();
    chk("rst_count",  int'(bus.count),  0);
    chk("rst_up_dn",  int'(bus.up_dn),  1);
    chk("rst_step",   int'(bus.step),   0);
    chk("rst_err",    int'(bus.err),    0);
    chk("rst_tercnt", int'(bus.tercnt), 1);
    cyc();
    reset = 1'b0;

`ifndef QDEC_FILTER_EN
    // vector table: reverse wrap to all-ones, illegal jump, forward wrap to 0
    tbl[0]  = '{2'b00, 0,    1, 0, 0, 0};
    tbl[1]  = '{2'b01, 0,    1, 0, 0, 0};
    tbl[2]  = '{2'b01, 0,    1, 0, 0, 0};
    tbl[3]  = '{2'b01, 8191, 0, 1, 0, 1};
    tbl[4]  = '{2'b10, 8191, 0, 0, 0, 1};
    tbl[5]  = '{2'b10, 8191, 0, 0, 0, 1};
    tbl[6]  = '{2'b10, 8191, 0, 0, 1, 1};
    tbl[7]  = '{2'b11, 8191, 0, 0, 0, 1};
    tbl[8]  = '{2'b11, 8191, 0, 0, 0, 1};
    tbl[9]  = '{2'b11, 0,    1, 1, 0, 0};
    tbl[10] = '{2'b11, 0,    1, 0, 0, 0};
    bus.count_to = 13'd8191;
    for (int unsigned i = 0; i < 11; i++) begin
      set_ab(tbl[i].ab);
      cyc();
      chk("tbl_count",  int'(bus.count),  tbl[i].exp_count);
      chk("tbl_up_dn",  int'(bus.up_dn),  int'(tbl[i].exp_up));
      chk("tbl_step",   int'(bus.step),   int'(tbl[i].exp_step));
      chk("tbl_err",    int'(bus.err),    int'(tbl[i].exp_err));
      chk("tbl_tercnt", int'(bus.tercnt), int'(tbl[i].exp_ter));
    end
`endif

    // 8 forward quadrature cycles, 4 clocks per phase
    set_ab(2'b00);
    bus.count_to = 13'd32;
    do_reset();
    repeat (4) cyc();
    n_step = 0; n_err = 0;
    for (int unsigned i = 1; i <= 32; i++) begin
      set_ab(ab_of(int'(i)));
      repeat (4) cyc();
    end
    repeat (LAT) cyc();
    chk("fwd_count",  int'(bus.count),  32);
    chk("fwd_up_dn",  int'(bus.up_dn),  1);
    chk("fwd_steps",  n_step,           32);
    chk("fwd_errs",   n_err,            0);
    chk("fwd_tercnt", int'(bus.tercnt), 1);

    // load coinciding with a decoded step wins, step discarded
    set_ab(2'b10);
    repeat (LAT - 1) cyc();
    bus.load = 0;
    bus.data = 13'd100;
    cyc();
    chk("load_count", int'(bus.count), 100);
    chk("load_step",  int'(bus.step),  0);
    bus.load = 1;
    bus.count_to = 13'd101;
    set_ab(2'b11);
    repeat (LAT) cyc();
    chk("after_load_count",  int'(bus.count),  101);
    chk("after_load_step",   int'(bus.step),   1);
    chk("after_load_tercnt", int'(bus.tercnt), 1);

    // illegal 11 -> 00 jump, then index clear
    set_ab(2'b00);
    repeat (LAT) cyc();
    chk("jump_err",   int'(bus.err),   1);
    chk("jump_count", int'(bus.count), 101);
    chk("jump_up_dn", int'(bus.up_dn), 1);
    cyc();
    chk("jump_err_pulse", int'(bus.err), 0);
    bus.idx_en = 1;
    bus.idx_in = 1;
    repeat (2) cyc();
    chk("idx_not_yet", int'(bus.count), 101);
    cyc();
    chk("idx_clear", int'(bus.count), 0);
    bus.idx_in = 0;
    bus.idx_en = 0;
    repeat (2) cyc();

    // cen low across 5 forward steps, then one enabled step
    n_step = 0; n_err = 0;
    bus.cen = 0;
    for (int unsigned i = 1; i <= 5; i++) begin
      set_ab(ab_of(int'(i)));
      repeat (4) cyc();
    end
    repeat (LAT) cyc();
    chk("cen_hold_count", int'(bus.count), 0);
    chk("cen_hold_steps", n_step, 0);
    bus.cen = 1;
    set_ab(ab_of(6));
    repeat (4 + LAT) cyc();
    chk("cen_count", int'(bus.count), 1);
    chk("cen_steps", n_step, 1);
    chk("cen_errs",  n_err, 0);

`ifdef QDEC_FILTER_EN
    // short A glitch rejected, stable A change accepted after 3+flt_len edges
    set_ab(2'b00);
    do_reset();
    repeat (8) cyc();
    n_step = 0;
    glitch_ab = 2'b10;
    set_ab(glitch_ab);
    repeat (2) cyc();
    set_ab(2'b00);
    repeat (10) cyc();
    chk("flt_glitch_steps", n_step, 0);
    chk("flt_glitch_count", int'(bus.count), 0);
    set_ab(glitch_ab);
    first_step = 0;
    for (int unsigned k = 1; k <= 10; k++) begin
      cyc();
      if (bus.step && first_step == 0) first_step = int'(k);
    end
    chk("flt_step_edge",  first_step, 6);
    chk("flt_step_count", int'(bus.count), 1);
`else
    // randomized traffic against the reference model
    set_ab(2'b00);
    do_reset();
    cur_ph = 0;
    chk_model = 1'b1;
    for (int unsigned n = 0; n < 4000; n++) begin
      r = int'($urandom_range(0, 15));
      if (r >= 8 && r < 11) cur_ph = (cur_ph + 1) % 4;
      else if (r >= 11 && r < 14) cur_ph = (cur_ph + 3) % 4;
      else if (r >= 14) cur_ph = (cur_ph + 2) % 4;
      set_ab(ab_of(cur_ph));
      bus.load = ($urandom_range(0, 31) != 0);
      bus.data = 13'($urandom);
      bus.cen  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) bus.idx_in = ~bus.idx_in;
      bus.idx_en = 1'($urandom);
      if ($urandom_range(0, 3) == 0) bus.count_to = 13'(m_pos);
      else if ($urandom_range(0, 7) == 0) bus.count_to = 13'($urandom);
      reset = ($urandom_range(0, 499) == 0);
      cyc();
    end
    chk_model = 1'b0;
    reset = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
